// File: rtl/darkroom_sensor_scheduler.sv
// Round-robin change detector for the lighthouse sensor bank: one sensor per clock,
// changed words are queued as {id, data} in a first-word-fall-through event FIFO.

module darkroom_shadow_lane #(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              sel,
    input  logic              eligible,
    input  logic [DATA_W-1:0] data,
    output logic              hit
);
    logic [DATA_W-1:0] shadow;

    assign hit = sel && eligible && (data != shadow);

    // Shadow follows every hit, including dropped ones, so a lost value is never replayed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)      shadow <= '0;
        else if (clear) shadow <= '0;
        else if (hit)   shadow <= data;
    end
endmodule

module darkroom_sensor_scheduler #(
    parameter int NUM_SENSORS = 32,
    parameter int FIFO_DEPTH  = 64,
    parameter int DATA_W      = 32,
    parameter int IDW         = $clog2(NUM_SENSORS),
    parameter int AW          = $clog2(FIFO_DEPTH),
    parameter int CW          = AW + 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_SENSORS*DATA_W-1:0] sensor_data_i,
    input  logic [NUM_SENSORS-1:0]        sensor_mask_i,
    input  logic                          enable_i,
    input  logic                          flush_i,
    input  logic                          pop_i,
    output logic                          evt_valid_o,
    output logic [IDW-1:0]                evt_id_o,
    output logic [DATA_W-1:0]             evt_data_o,
    output logic [CW-1:0]                 evt_count_o,
    output logic [15:0]                   overflow_o,
    output logic                          lap_done_o
);
    typedef enum logic {IDLE, SCAN} state_t;

    localparam logic [IDW-1:0] LAST_IDX = IDW'(NUM_SENSORS - 1);

    state_t                   state;
    logic [IDW-1:0]           scan_idx;
    logic                     scan_active;
    logic [NUM_SENSORS-1:0]   hit_vec;
    logic                     hit;
    logic [DATA_W-1:0]        cur_data;

    logic [IDW-1:0]           mem_id   [FIFO_DEPTH];
    logic [DATA_W-1:0]        mem_data [FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr, rd_ptr;
    logic                     room, do_push, do_pop, drop;

    assign scan_active = (state == SCAN) && enable_i;
    assign cur_data    = sensor_data_i[scan_idx*DATA_W +: DATA_W];

    genvar k;
    generate
        for (k = 0; k < NUM_SENSORS; k++) begin : g_lane
            darkroom_shadow_lane #(.DATA_W(DATA_W)) u_lane (
                .clock    (clock),
                .reset    (reset),
                .clear    (flush_i),
                .sel      (scan_active && (scan_idx == IDW'(k))),
                .eligible (sensor_mask_i[k]),
                .data     (sensor_data_i[k*DATA_W +: DATA_W]),
                .hit      (hit_vec[k])
            );
        end
    endgenerate

    assign hit = |hit_vec;

    // A pop in the same cycle frees a slot, so a full FIFO can still accept a push.
    assign evt_valid_o = (evt_count_o != '0);
    assign room        = (evt_count_o < CW'(FIFO_DEPTH)) || (pop_i && evt_valid_o);
    assign do_pop      = pop_i && evt_valid_o && !flush_i;
    assign do_push     = hit && room && !flush_i;
    assign drop        = hit && !room && !flush_i;

    assign evt_id_o   = evt_valid_o ? mem_id[rd_ptr]   : '0;
    assign evt_data_o = evt_valid_o ? mem_data[rd_ptr] : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            scan_idx   <= '0;
            lap_done_o <= 1'b0;
        end else begin
            lap_done_o <= 1'b0;
            case (state)
                IDLE: if (enable_i) state <= SCAN;
                SCAN: begin
                    if (!enable_i) begin
                        state    <= IDLE;
                        scan_idx <= '0;
                    end else begin
                        scan_idx   <= (scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1;
                        lap_done_o <= (scan_idx == LAST_IDX);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            evt_count_o <= '0;
            overflow_o  <= '0;
        end else if (flush_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            evt_count_o <= '0;
            overflow_o  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   evt_count_o <= evt_count_o + 1'b1;
                2'b01:   evt_count_o <= evt_count_o - 1'b1;
                default: evt_count_o <= evt_count_o;
            endcase
            if (drop && overflow_o != 16'hFFFF) overflow_o <= overflow_o + 16'd1;
        end
    end

    // Storage carries no reset; the head is masked to zero while the FIFO is empty.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_id[wr_ptr]   <= scan_idx;
            mem_data[wr_ptr] <= cur_data;
        end
    end
endmodule

// File: tb/tb_darkroom_sensor_scheduler.sv
// Randomized bench for darkroom_sensor_scheduler against a queue-based event model,
// plus directed scenarios for single events, coalescing, masking, overflow, flush and reset.
module tb_darkroom_sensor_scheduler;
    localparam int N     = 32;
    localparam int DEPTH = 64;
    localparam int DW    = 32;
    localparam int IDW   = 5;
    localparam int CW    = 7;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [DW-1:0]  data;
    } evt_t;

    logic              clock = 1'b0;
    logic              reset;
    logic [N*DW-1:0]   sensor_data_i;
    logic [N-1:0]      sensor_mask_i;
    logic              enable_i, flush_i, pop_i;
    logic              evt_valid_o;
    logic [IDW-1:0]    evt_id_o;
    logic [DW-1:0]     evt_data_o;
    logic [CW-1:0]     evt_count_o;
    logic [15:0]       overflow_o;
    logic              lap_done_o;

    always #5 clock = ~clock;

    darkroom_sensor_scheduler dut (
        .clock         (clock),
        .reset         (reset),
        .sensor_data_i (sensor_data_i),
        .sensor_mask_i (sensor_mask_i),
        .enable_i      (enable_i),
        .flush_i       (flush_i),
        .pop_i         (pop_i),
        .evt_valid_o   (evt_valid_o),
        .evt_id_o      (evt_id_o),
        .evt_data_o    (evt_data_o),
        .evt_count_o   (evt_count_o),
        .overflow_o    (overflow_o),
        .lap_done_o    (lap_done_o)
    );

    // Reference model: shadow table, event queue, drop counter, scan position.
    logic [DW-1:0] m_shadow [N];
    evt_t          m_q [$];
    int            m_ovf;
    bit            m_scan;
    int            m_idx;
    bit            m_lap;
    int            n_chk = 0;
    int            n_err = 0;
    int            laps  = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (m_shadow[k]) m_shadow[k] = '0;
        m_q.delete();
        m_ovf  = 0;
        m_scan = 0;
        m_idx  = 0;
        m_lap  = 0;
    endtask

    task automatic model_step();
        bit            pop_ok, room, push;
        evt_t          e;
        logic [DW-1:0] d;
        pop_ok = pop_i && (m_q.size() > 0);
        room   = (m_q.size() < DEPTH) || pop_ok;
        push   = 0;
        e      = '0;
        m_lap  = 0;
        if (m_scan && enable_i) begin
            d = sensor_data_i[m_idx*DW +: DW];
            if (!flush_i && sensor_mask_i[m_idx] && d != m_shadow[m_idx]) begin
                m_shadow[m_idx] = d;
                if (room) begin
                    push   = 1;
                    e.id   = IDW'(m_idx);
                    e.data = d;
                end else if (m_ovf < 65535) m_ovf++;
            end
            m_lap = (m_idx == N - 1);
            m_idx = (m_idx + 1) % N;
        end else if (m_scan) begin
            m_scan = 0;
            m_idx  = 0;
        end else if (enable_i) m_scan = 1;
        if (flush_i) begin
            m_q.delete();
            foreach (m_shadow[k]) m_shadow[k] = '0;
            m_ovf = 0;
        end else begin
            if (pop_ok) m_q.delete(0);
            if (push)   m_q.push_back(e);
        end
    endtask

    task automatic check_all();
        bit ne;
        ne = (m_q.size() > 0);
        chk("valid",    evt_valid_o, ne);
        chk("id",       evt_id_o,    ne ? m_q[0].id   : '0);
        chk("data",     evt_data_o,  ne ? m_q[0].data : '0);
        chk("count",    evt_count_o, m_q.size());
        chk("overflow", overflow_o,  m_ovf);
        chk("lap_done", lap_done_o,  m_lap);
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        if (lap_done_o) laps++;
        check_all();
    endtask

    task automatic set_sensor(input int k, input logic [DW-1:0] v);
        sensor_data_i[k*DW +: DW] = v;
    endtask

    task automatic drain();
        pop_i = 1;
        for (int g = 0; g < DEPTH + 4 && m_q.size() > 0; g++) tick();
        pop_i = 0;
        chk("drain_empty", evt_valid_o, 1'b0);
    endtask

    task automatic seek(input int idx);
        for (int g = 0; g < N + 2 && m_idx != idx; g++) tick();
        chk("seek_idx", m_idx, idx);
    endtask

    initial begin
        int base;
        reset = 1; enable_i = 0; flush_i = 0; pop_i = 0;
        sensor_data_i = '0; sensor_mask_i = '0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_all();
        reset = 0;

        // Single nonzero sensor: one event, lap pulse every 32 scan cycles.
        sensor_mask_i = '1;
        set_sensor(5, 32'h8000_1234);
        enable_i = 1;
        laps = 0;
        repeat (80) tick();
        chk("t1_count", evt_count_o, 1);
        chk("t1_id",    evt_id_o,    5);
        chk("t1_data",  evt_data_o,  32'h8000_1234);
        chk("t1_laps",  laps,        2);
        drain();

        // Three values inside one lap collapse into a single event.
        seek(8);
        set_sensor(7, 32'hA); repeat (5) tick();
        set_sensor(7, 32'hB); repeat (5) tick();
        set_sensor(7, 32'hC);
        repeat (32) tick();
        chk("t2_count", evt_count_o, 1);
        chk("t2_data",  evt_data_o,  32'hC);
        drain();

        // Masked sensor is ignored until unmasked.
        sensor_mask_i[3] = 1'b0;
        for (int r = 0; r < 3; r++) begin
            set_sensor(3, 32'h300 + r);
            repeat (32) tick();
        end
        chk("t4_masked", evt_count_o, 0);
        sensor_mask_i[3] = 1'b1;
        repeat (32) tick();
        chk("t4_count", evt_count_o, 1);
        chk("t4_data",  evt_data_o,  32'h302);
        drain();

        // Three laps of all-changing sensors with no pops: 64 held, 32 dropped.
        enable_i = 0; tick();
        flush_i = 1; tick(); flush_i = 0;
        enable_i = 1; tick();
        for (int c = 0; c < 96; c++) begin
            for (int k = 0; k < N; k++) set_sensor(k, 32'h1000 + c);
            tick();
        end
        chk("t3_count", evt_count_o, 64);
        chk("t3_ovf",   overflow_o,  32);
        for (int k = 0; k < N; k++) set_sensor(k, 32'h2000);
        pop_i = 1; tick(); pop_i = 0;
        chk("t3_full_pp_count", evt_count_o, 64);
        chk("t3_full_pp_ovf",   overflow_o,  32);

        // Pop on empty is harmless; flush beats a pending push.
        sensor_data_i = '0;
        flush_i = 1; tick(); flush_i = 0;
        pop_i = 1;
        repeat (5) tick();
        chk("t5_empty_pop", evt_count_o, 0);
        set_sensor(m_idx, 32'hDEAD);
        flush_i = 1; tick(); flush_i = 0; pop_i = 0;
        chk("t5_flush_count", evt_count_o, 0);
        chk("t5_flush_ovf",   overflow_o,  0);
        sensor_data_i = '0;
        flush_i = 1; tick(); flush_i = 0;

        // Disable at index 17 restarts the scan at sensor 0.
        seek(17);
        enable_i = 0; tick();
        set_sensor(0, 32'h55);
        set_sensor(18, 32'h66);
        enable_i = 1; tick(); tick();
        chk("t6_restart_valid", evt_valid_o, 1'b1);
        chk("t6_restart_id",    evt_id_o,    0);
        repeat (20) tick();

        // Asynchronous reset mid-lap clears outputs without a clock edge.
        #2 reset = 1;
        #1;
        chk("rst_valid", evt_valid_o, 1'b0);
        chk("rst_count", evt_count_o, 0);
        chk("rst_id",    evt_id_o,    0);
        chk("rst_ovf",   overflow_o,  0);
        chk("rst_lap",   lap_done_o,  1'b0);
        model_reset();
        @(posedge clock); #1;
        reset = 0;
        check_all();

        // Randomized traffic.
        base = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0)
                set_sensor($urandom_range(0, N - 1),
                           ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom);
            if ($urandom_range(0, 63) == 0) sensor_mask_i[$urandom_range(0, N - 1)] ^= 1'b1;
            pop_i   = ($urandom_range(0, 2) != 0);
            flush_i = ($urandom_range(0, 199) == 0);
            if (enable_i) enable_i = ($urandom_range(0, 99) != 0);
            else          enable_i = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 499) == 0) begin
                for (int k = 0; k < N; k++) set_sensor(k, $urandom);
                pop_i = 0;
            end
            tick();
            base++;
        end
        pop_i = 0; flush_i = 0;
        chk("rand_cycles", base, 3000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
